pc_ras: RTL and testbench

- Parametrised program-counter unit for the fetch stage. Successor to the basic count/branch PC.
- Adds the following over a plain count/branch PC:
  - stall (hold);
  - configurable width, reset vector and increment;
  - call/return handling through an internal circular return-address stack (RAS) with overflow and underflow reporting.
- Drives the instruction-memory address. Branch, call and return requests come from the decode/execute control.

---
 rtl/pc_ras.sv | 131 +++++++++++++
 tb/tb_pc_ras.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_ras.sv
// pc_ras -- fetch-stage program counter with stall, branch, and call/return
// through a circular return-address stack (RAS).
//
// Ports:
//   clk            CPU clock; all state changes on its rising edge.
//   resetn         Synchronous active-low reset.
//   stall          Hold PC and stack; all requests this cycle are dropped.
//   branch_valid   Load cnt from branch_address.
//   call_valid     Load cnt from branch_address and push cnt+INC.
//   ret_valid      Load cnt from the top of stack and pop.
//   branch_address Target of a branch or call.
//   cnt            Registered program count.
//   ras_top        Top-of-stack entry, 0 when the stack is empty.
//   ras_count      Number of valid stack entries.
//   ras_overflow   One-cycle pulse after a call pushed into a full stack.
//   ras_underflow  One-cycle pulse after a return on an empty stack.
//
// Priority per edge: reset > stall > call > branch > ret > increment.
module pc_ras #(
    parameter int ADDR_W     = 11,
    parameter int RAS_DEPTH  = 8,
    parameter int RESET_ADDR = 0,
    parameter int INC        = 1,
    localparam int CNT_W     = $clog2(RAS_DEPTH + 1),
    localparam int PTR_W     = $clog2(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic              call_valid,
    input  logic              ret_valid,
    input  logic [ADDR_W-1:0] branch_address,
    output logic [ADDR_W-1:0] cnt,
    output logic [ADDR_W-1:0] ras_top,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam logic [ADDR_W-1:0] INC_A   = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] RST_A   = ADDR_W'(RESET_ADDR);
    localparam logic [CNT_W-1:0]  FULL    = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0]  LAST    = PTR_W'(RAS_DEPTH - 1);

    // Stack storage; sp_q is the next slot to write. When the stack is full
    // sp_q points at the oldest entry, so a push simply overwrites it.
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              mem_we;
    logic [ADDR_W-1:0] seq_addr;
    logic [PTR_W-1:0]  sp_inc;
    logic [PTR_W-1:0]  sp_dec;
    logic              empty;

    // Pointer arithmetic is explicit so non-power-of-two depths wrap correctly.
    assign sp_inc   = (sp_q == LAST) ? '0 : sp_q + PTR_W'(1);
    assign sp_dec   = (sp_q == '0) ? LAST : sp_q - PTR_W'(1);
    assign seq_addr = cnt_q + INC_A;
    assign empty    = (count_q == '0);

    always_comb begin
        cnt_d   = cnt_q;
        sp_d    = sp_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        mem_we  = 1'b0;
        if (!stall) begin
            if (call_valid) begin
                cnt_d  = branch_address;
                mem_we = 1'b1;
                sp_d   = sp_inc;
                if (count_q == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end else if (branch_valid) begin
                cnt_d = branch_address;
            end else if (ret_valid) begin
                if (!empty) begin
                    cnt_d   = ras_mem[sp_dec];
                    sp_d    = sp_dec;
                    count_d = count_q - CNT_W'(1);
                end else begin
                    cnt_d = seq_addr;
                    unf_d = 1'b1;
                end
            end else begin
                cnt_d = seq_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q   <= RST_A;
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage has no reset; a push is suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (resetn && mem_we) begin
            ras_mem[sp_q] <= seq_addr;
        end
    end

    assign cnt           = cnt_q;
    assign ras_count     = count_q;
    assign ras_top       = empty ? '0 : ras_mem[sp_dec];
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
module tb_pc_ras;

    localparam int AW    = 11;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          stall = 1'b0;
    logic          branch_valid = 1'b0;
    logic          call_valid = 1'b0;
    logic          ret_valid = 1'b0;
    logic [AW-1:0] branch_address = '0;
    logic [AW-1:0] cnt;
    logic [AW-1:0] ras_top;
    logic [CW-1:0] ras_count;
    logic          ras_overflow;
    logic          ras_underflow;

    int vectors = 0;
    int miscompares = 0;

    pc_ras #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_ADDR(0), .INC(1)) dut (
        .clk(clk), .resetn(resetn), .stall(stall),
        .branch_valid(branch_valid), .call_valid(call_valid), .ret_valid(ret_valid),
        .branch_address(branch_address), .cnt(cnt), .ras_top(ras_top),
        .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: the stack is a queue whose back is the top.
    logic [AW-1:0] m_cnt = '0;
    logic [AW-1:0] m_stack [$];
    bit            m_ovf = 0;
    bit            m_unf = 0;
    bit            m_valid = 0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_cnt = '0;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
            m_valid = 1;
        end else begin
            m_ovf = 0;
            m_unf = 0;
            if (stall) begin
            end else if (call_valid) begin
                if (m_stack.size() == DEPTH) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1;
                end
                m_stack.push_back(m_cnt + AW'(1));
                m_cnt = branch_address;
            end else if (branch_valid) begin
                m_cnt = branch_address;
            end else if (ret_valid) begin
                if (m_stack.size() > 0) begin
                    m_cnt = m_stack.pop_back();
                end else begin
                    m_cnt = m_cnt + AW'(1);
                    m_unf = 1;
                end
            end else begin
                m_cnt = m_cnt + AW'(1);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cnt", int'(cnt), int'(m_cnt));
            chk("ras_count", int'(ras_count), m_stack.size());
            chk("ras_top", int'(ras_top), (m_stack.size() > 0) ? int'(m_stack[$]) : 0);
            chk("ras_overflow", int'(ras_overflow), int'(m_ovf));
            chk("ras_underflow", int'(ras_underflow), int'(m_unf));
        end
    end

    // Drive one cycle's inputs, let the edge happen, return 1 time unit later.
    task automatic step(input bit rn, input bit st, input bit cl, input bit br,
                        input bit rt, input logic [AW-1:0] addr);
        resetn = rn; stall = st; call_valid = cl; branch_valid = br;
        ret_valid = rt; branch_address = addr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, '0);
    endtask

    initial begin
        logic [AW-1:0] held;

        // Reset and count
        step(0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, '0);
        chk("reset_cnt", int'(cnt), 0);
        chk("reset_count", int'(ras_count), 0);
        chk("reset_flags", int'({ras_overflow, ras_underflow}), 0);
        for (int i = 1; i <= 5; i++) begin
            idle();
            chk("count_up", int'(cnt), i);
        end

        // Wrap-around
        step(1, 0, 0, 1, 0, 11'h7FE);
        chk("wrap_br", int'(cnt), 'h7FE);
        idle(); chk("wrap_1", int'(cnt), 'h7FF);
        idle(); chk("wrap_2", int'(cnt), 'h000);
        idle(); chk("wrap_3", int'(cnt), 'h001);

        // Call and return
        step(1, 0, 0, 1, 0, 11'h010);
        step(1, 0, 1, 0, 0, 11'h200);
        chk("call_cnt", int'(cnt), 'h200);
        chk("call_top", int'(ras_top), 'h011);
        chk("call_count", int'(ras_count), 1);
        for (int i = 1; i <= 3; i++) begin
            idle();
            chk("call_seq", int'(cnt), 'h200 + i);
        end
        step(1, 0, 0, 0, 1, '0);
        chk("ret_cnt", int'(cnt), 'h011);
        chk("ret_count", int'(ras_count), 0);

        // Nested overflow
        step(1, 0, 0, 1, 0, 11'h010);
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 1, 0, 0, AW'(11'h100 + i));
            chk("ovf_flag", int'(ras_overflow), (i == 8) ? 1 : 0);
        end
        chk("ovf_count", int'(ras_count), DEPTH);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0, 1, '0);
            chk("ovf_ret", int'(cnt), 'h108 - i);
            chk("ovf_pulse_gone", int'(ras_overflow), 0);
        end
        chk("ovf_empty", int'(ras_count), 0);

        // Underflow
        step(1, 0, 0, 1, 0, 11'h020);
        step(1, 0, 0, 0, 1, '0);
        chk("unf_cnt", int'(cnt), 'h021);
        chk("unf_flag", int'(ras_underflow), 1);
        chk("unf_count", int'(ras_count), 0);
        idle();
        chk("unf_pulse_gone", int'(ras_underflow), 0);

        // Stall and priority
        held = cnt;
        step(1, 1, 1, 1, 1, 11'h300);
        chk("stall_cnt", int'(cnt), int'(held));
        chk("stall_count", int'(ras_count), 0);
        step(1, 0, 1, 1, 0, 11'h300);
        chk("prio_cnt", int'(cnt), 'h300);
        chk("prio_count", int'(ras_count), 1);
        chk("prio_top", int'(ras_top), int'(held) + 1);
        step(0, 0, 1, 0, 0, 11'h400);
        chk("rst_mid_cnt", int'(cnt), 0);
        chk("rst_mid_count", int'(ras_count), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0),
                 AW'($urandom));
        end
        idle();
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
